// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and width helper for the piso transmitter
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - loadable zero-fill shift register presenting one serial bit
module piso_shreg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sbit
);

    logic [WIDTH-1:0] q;

    // Zero fill means one extra shift after the last bit leaves the register clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            if (MSB_FIRST) begin
                q <= {q[WIDTH-2:0], 1'b0};
            end else begin
                q <= {1'b0, q[WIDTH-1:1]};
            end
        end
    end

    assign sbit = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with gapless back-to-back words
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CW = clog2(WIDTH);

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          last;
    logic          accept;
    logic          shift;
    logic          in_shift;
    logic          sbit;

    assign last       = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));
    assign load_ready = !rst && ((state == ST_IDLE) || last);
    assign accept     = load_valid && load_ready;
    assign shift      = (state == ST_SHIFT) && !accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_SHIFT;
                    next_cnt   = '0;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    next_cnt = '0;
                end else if (last) begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .din   (din),
        .sbit  (sbit)
    );

    // Outputs are forced low while reset is held, even before the reset edge lands.
    assign in_shift   = !rst && (state == ST_SHIFT);
    assign sout_valid = in_shift;
    assign sout       = in_shift && sbit;
    assign done       = in_shift && last;

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter. It is the sending end for the team's serial shift chains and serial-in receivers. It accepts a WIDTH-bit word through a valid/ready load handshake and emits the word one bit per clock on sout, qualified by sout_valid. Back-to-back words stream with no idle bubble between them.

Parameters:
WIDTH, 4, word length in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
din  input  WIDTH  parallel word; sampled only when a load is accepted.
load_valid  input  1  source has a word on din.
load_ready  output  1  block can accept a word this cycle.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a valid bit this cycle.
done  output  1  one-cycle pulse that coincides with the last bit of a word.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- State machine states:
  - ST_IDLE: no word in flight.
  - ST_SHIFT: word in flight.
- Internal state:
  - shreg[WIDTH-1:0] holds the word being sent.
  - cnt[$clog2(WIDTH)-1:0] holds the index of the bit currently on sout.
- Reset (rst=1 at a rising edge) sets: state=ST_IDLE, shreg=0, cnt=0.
- While rst=1:
  - load_ready=0, sout=0, sout_valid=0, done=0.
  - Any load_valid is ignored.
- Reset mid-word aborts the word. No done pulse is emitted and the remaining bits are discarded.
- Load acceptance:
  - A load is accepted when load_valid && load_ready at a rising edge.
  - load_ready = !rst && (state==ST_IDLE || (state==ST_SHIFT && cnt==WIDTH-1)).
- Accept edge updates: shreg<=din, cnt<=0, state<=ST_SHIFT.
- Latency: the first bit appears on sout in the cycle immediately after the accept edge, i.e. zero extra bubble.
- Outputs are combinational decodes of registered state:
  - sout_valid = (state==ST_SHIFT).
  - sout = sout_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 0.
  - done = (state==ST_SHIFT && cnt==WIDTH-1).
- ST_SHIFT, cnt<WIDTH-1, at each edge:
  - cnt<=cnt+1.
  - MSB_FIRST=1: shreg shifts left with 0 fill.
  - MSB_FIRST=0: shreg shifts right with 0 fill.
  - load_valid is ignored, because load_ready=0 in these cycles.
- ST_SHIFT, cnt==WIDTH-1, at the edge:
  - If a load is accepted, the new word is loaded, cnt<=0 and the state stays ST_SHIFT, giving a contiguous stream.
  - Otherwise state<=ST_IDLE and shreg<=0.
- A word occupies exactly WIDTH consecutive sout_valid cycles.
- din changing outside the accept edge has no effect.
- cnt never exceeds WIDTH-1; there is no wrap beyond the word.
- Simultaneous rst and load_valid: reset wins and the word is not accepted.

Decomposition:
- Shared package piso_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - a counter-width function clog2.
- One sub-module, piso_shreg. It is a WIDTH-bit loadable shift register with inputs clk, rst, load, shift, din and parameter MSB_FIRST, and output serial bit.
- The FSM, counter and handshake stay in piso_tx.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with load_valid=1 and din=4'hF. Required: load_ready=0, sout=0, sout_valid=0, done=0 throughout. After release: load_ready=1, sout_valid=0.
2. Single word: WIDTH=4, MSB_FIRST=1, din=4'b1011, load_valid pulsed for one cycle. Required: sout=1,0,1,1 on the next 4 cycles with sout_valid=1, and done=1 only on the 4th. In the following cycle sout_valid=0, sout=0, load_ready=1.
3. Back-to-back: 4'b1011, then 4'b0110 presented on the cycle where load_ready reasserts. Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0, done on bits 4 and 8, no gap.
4. Mid-word load ignored: while bit 2 of 4'b1011 is on sout, pulse load_valid with din=4'b1111. Required: load_ready=0 during the pulse and the output stream stays 1,0,1,1.
5. Reset mid-word: assert rst after 2 bits of 4'b1011. Required: sout_valid=0 the next cycle and no done. A subsequent load of 4'b0101 transmits 0,1,0,1 correctly.
6. LSB-first: MSB_FIRST=0, din=4'b1011. Required: sout=1,1,0,1 with done on the 4th bit.
